fifo_stream_reader: RTL and testbench

- Read-side drain engine for the dual-clock FIFO, clocked entirely in the read domain.
- Drives the FIFO read port (rd_en, rd_data, empty) and presents the words on a valid/ready stream with a 2-entry skid buffer. The buffer hides the FIFO's 1-cycle registered read latency while sustaining 1 word/cycle.
- Frames the stream into fixed-length packets (m_last) and counts completed packets.

---
 rtl/fifo_stream_reader.sv | 123 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine for the dual-clock FIFO.
// Issues FIFO reads on a credit basis, lands the registered read data in a
// 2-entry skid buffer, presents it as a valid/ready stream and frames the
// stream into fixed-length packets.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PKT_LEN    = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    localparam int unsigned BeatWidth = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(PKT_LEN - 1);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [BeatWidth-1:0]  beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
    logic                  pop;
    logic                  push;
    logic [2:0]            level;

    assign pop  = m_valid & m_ready;
    assign push = inflight_q;

    // Entries that will be held after this cycle if no new read is issued.
    // Using the current pop here (m_ready -> fifo_rd_en) is what keeps 1 word/cycle.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign fifo_rd_en = en & ~fifo_empty & ~rst & (level < 3'd2);

    // Outputs come straight from the buffer head and framing counter.
    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = head_q;
    assign m_last    = m_valid & (beat_q == LastBeat);
    assign pkt_count = pkt_q;

    // Skid buffer next state: head is always the oldest word, tail the second.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_rd_data;
                end else begin
                    tail_d = fifo_rd_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the head advances.
                if (occ_q == 2'd1) begin
                    head_d = fifo_rd_data;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    // Packet framing: beat position and completed-packet count advance on pop.
    always_comb begin
        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (pop) begin
            if (m_last) begin
                beat_d = '0;
                pkt_d  = pkt_q + CNT_WIDTH'(1);
            end else begin
                beat_d = beat_q + BeatWidth'(1);
            end
        end
    end

    // State registers; reset discards buffered and in-flight words.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            beat_q     <= '0;
            pkt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_q     <= beat_d;
            pkt_q      <= pkt_d;
        end
    end

    // The credit rule must keep the buffer from overflowing and never read an empty FIFO.
    always_ff @(posedge rd_clk) begin
        if (!rst) begin
            assert (level <= 3'd2);
            assert (!(fifo_rd_en && fifo_empty));
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and random-stall bench for fifo_stream_reader with a FIFO model
// and a scoreboard queue of expected stream words.
module tb_fifo_stream_reader;

    localparam int PktLen = 4;

    logic        rd_clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_empty;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [15:0] pkt_count;

    // FIFO model: storage filled by the stimulus, drained by the read port.
    logic [7:0]  mem [0:2047];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        fifo_flush;

    int          n_asserts = 0;
    int          n_fail = 0;
    int          outstanding;
    int          reads_total;
    int          pops_total;
    int          tb_beat;
    int          tb_pkt;
    logic [7:0]  exp_q [$];
    logic        hold_pending;
    logic [7:0]  hold_data;
    logic        hold_last;

    fifo_stream_reader #(
        .DATA_WIDTH(8),
        .PKT_LEN   (PktLen),
        .CNT_WIDTH (16)
    ) dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .en          (en),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .pkt_count   (pkt_count)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr[10:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr[10:0]] = d;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(d);
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge rd_clk);
        if (rst) begin
            hold_pending = 1'b0;
            check("rst_rd_en", fifo_rd_en, 0);
        end else begin
            check("occ_bound", outstanding <= 2, 1);
            if (!m_valid) check("m_last_idle", m_last, 0);
            if (hold_pending) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hold_data);
                check("hold_last", m_last, hold_last);
            end
            hold_pending = m_valid && !m_ready;
            hold_data    = m_data;
            hold_last    = m_last;
            if (fifo_rd_en) begin
                check("rd_en_empty", fifo_empty, 0);
                check("rd_en_en", en, 1);
                outstanding++;
                reads_total++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e);
                end
                check("m_last", m_last, tb_beat == PktLen - 1);
                tb_beat = (tb_beat + 1) % PktLen;
                if (tb_beat == 0) tb_pkt++;
                outstanding--;
                pops_total++;
            end
        end
        @(posedge rd_clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, exp_q.size() == 0 && !m_valid, 1);
    endtask

    initial begin
        int r0;
        int p0;
        int d0;
        int target;
        int n;
        int pushed;
        int k;

        rst          = 1'b1;
        en           = 1'b1;
        m_ready      = 1'b1;
        fifo_flush   = 1'b0;
        outstanding  = 0;
        reads_total  = 0;
        pops_total   = 0;
        tb_beat      = 0;
        tb_pkt       = 0;
        hold_pending = 1'b0;

        // Reset held with a non-empty FIFO.
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        repeat (3) begin
            tick();
            check("rst_valid", m_valid, 0);
            check("rst_last", m_last, 0);
        end
        check("rst_pkt", pkt_count, 0);
        check("rst_data", m_data, 0);

        // Streaming 0x01..0x08 with latency check.
        rst = 1'b0;
        #1;
        check("first_rd_en", fifo_rd_en, 1);
        check("lat_n0_valid", m_valid, 0);
        tick();
        check("lat_n1_valid", m_valid, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", m_valid, 1);
            check("stream_data", m_data, i + 1);
            tick();
        end
        check("stream_end_valid", m_valid, 0);
        check("stream_pkt", pkt_count, 2);

        // Backpressure: only two reads issued while stalled.
        m_ready = 1'b0;
        r0 = reads_total;
        for (int i = 0; i < 6; i++) push_word(8'(8'h10 + i));
        repeat (10) tick();
        check("bp_reads", reads_total - r0, 2);
        check("bp_valid", m_valid, 1);
        check("bp_head", m_data, 8'h10);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("bp_valid_run", m_valid, 1);
            check("bp_data", m_data, 8'h10 + i);
            tick();
        end
        check("bp_end_valid", m_valid, 0);
        check("bp_pkt", pkt_count, 3);

        // en gating mid-packet.
        for (int i = 0; i < 12; i++) push_word(8'(8'h20 + i));
        target = pops_total + 4;
        n = 0;
        while (pops_total < target && n < 50) begin
            tick();
            n++;
        end
        check("en_pre_pops", pops_total, target);
        en = 1'b0;
        #1;
        check("en_off_rd_en", fifo_rd_en, 0);
        d0 = outstanding;
        p0 = pops_total;
        repeat (6) tick();
        check("en_drain_count", pops_total - p0, d0);
        check("en_drained_valid", m_valid, 0);
        check("en_off_rd_en2", fifo_rd_en, 0);
        en = 1'b1;
        drain("en", 60);
        check("en_pkt", pkt_count, 6);

        // Reset while the buffer is full.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'(8'h30 + i));
        repeat (5) tick();
        check("mrst_pre_valid", m_valid, 1);
        rst        = 1'b1;
        fifo_flush = 1'b1;
        #1;
        check("mrst_valid", m_valid, 0);
        check("mrst_rd_en", fifo_rd_en, 0);
        check("mrst_last", m_last, 0);
        exp_q.delete();
        outstanding  = 0;
        tb_beat      = 0;
        tb_pkt       = 0;
        hold_pending = 1'b0;
        repeat (2) tick();
        rst        = 1'b0;
        fifo_flush = 1'b0;
        #1;
        check("mrst_pkt", pkt_count, 0);
        check("mrst_post_valid", m_valid, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'(8'h40 + i));
        drain("mrst", 20);
        check("mrst_pkt_after", pkt_count, 1);

        // Random fill and random stall, 1000 words.
        pushed = 0;
        n = 0;
        while ((pushed < 1000 || exp_q.size() != 0 || m_valid) && n < 20000) begin
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(1, 3));
                for (int j = 0; j < k && pushed < 1000; j++) begin
                    push_word(8'($urandom));
                    pushed++;
                end
            end
            m_ready = ($urandom_range(0, 1) == 1);
            tick();
            n++;
        end
        m_ready = 1'b1;
        check("rand_drained", pushed == 1000 && exp_q.size() == 0 && !m_valid, 1);
        check("rand_pkt", pkt_count, 251);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
